// File: rtl/ps2_scan_rx_if.sv
// PS/2 receiver bundle: raw pin inputs plus decoded byte/key outputs.
//
// Handshake: there is no ready and no back-pressure. code_valid, key_valid
// and frame_err are single-cycle pulses. The consumer must sample code /
// keycodeout on code_valid and key_code / key_release / key_ext on
// key_valid. A later byte overwrites code whether or not it was consumed.
interface ps2_scan_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [7:0]  code;
    logic        code_valid;
    logic [31:0] keycodeout;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_release;
    logic        key_ext;
    logic        frame_err;
    logic [1:0]  state_dbg;

    // Receiver side: pins in, decoded results and FSM state out.
    modport slave (
        input  ps2_clk, ps2_data,
        output code, code_valid, keycodeout, key_valid, key_code,
        output key_release, key_ext, frame_err, state_dbg
    );

    // Pin driver / consumer side.
    modport master (
        output ps2_clk, ps2_data,
        input  code, code_valid, keycodeout, key_valid, key_code,
        input  key_release, key_ext, frame_err, state_dbg
    );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver. It synchronizes both pins and debounces the
// clock. It deserializes 11-bit frames and checks the start, parity and stop
// bits. It publishes each good byte, a 32-bit history of bytes, and
// make/break/extended key events.
module ps2_scan_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 25000
) (
    input logic          clk,
    input logic          rst,
    ps2_scan_rx_if.slave bus
);
    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Input path
    logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic              filt_q, filt_d;
    logic [FILT_W-1:0] fcnt_q, fcnt_d;
    logic              strobe_q, strobe_d;

    // Frame FSM
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              byte_done, frame_bad;

    // Outputs and prefix flags
    logic [7:0]        code_q, code_d;
    logic              code_valid_q, code_valid_d;
    logic [31:0]       hist_q, hist_d;
    logic              key_valid_q, key_valid_d;
    logic [7:0]        key_code_q, key_code_d;
    logic              key_release_q, key_release_d;
    logic              key_ext_q, key_ext_d;
    logic              frame_err_q, frame_err_d;
    logic              rel_flag_q, rel_flag_d;
    logic              ext_flag_q, ext_flag_d;

    // Clock filter: flip the level only after FILTER_LEN samples in a row
    // disagree with it. Emit a strobe on the cycle the level drops to 0.
    always_comb begin
        filt_d   = filt_q;
        fcnt_d   = '0;
        strobe_d = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_d   = clk_s2_q;
                strobe_d = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Pin synchronizers and filter state. Idle-high pins reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            clk_s1_q <= bus.ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= bus.ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            strobe_q <= strobe_d;
        end
    end

    // Frame FSM: advance one bit per falling-edge strobe. Abandon a stalled
    // frame once the inter-edge timer expires. A strobe beats expiry.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        if (strobe_q) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
                state_d   = S_IDLE;
                tmo_d     = '0;
                frame_bad = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

    // Byte publication and key decode. F0/E0 only arm their flags. Any
    // other byte is a key event that reports the flags and then clears them.
    always_comb begin
        code_d        = code_q;
        code_valid_d  = 1'b0;
        hist_d        = hist_q;
        key_valid_d   = 1'b0;
        key_code_d    = key_code_q;
        key_release_d = key_release_q;
        key_ext_d     = key_ext_q;
        rel_flag_d    = rel_flag_q;
        ext_flag_d    = ext_flag_q;
        frame_err_d   = frame_bad;
        if (byte_done) begin
            code_d       = shift_q;
            code_valid_d = 1'b1;
            hist_d       = {hist_q[23:0], shift_q};
            if (shift_q == 8'hF0) begin
                rel_flag_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_flag_d = 1'b1;
            end else begin
                key_valid_d   = 1'b1;
                key_code_d    = shift_q;
                key_release_d = rel_flag_q;
                key_ext_d     = ext_flag_q;
                rel_flag_d    = 1'b0;
                ext_flag_d    = 1'b0;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q        <= '0;
            code_valid_q  <= 1'b0;
            hist_q        <= '0;
            key_valid_q   <= 1'b0;
            key_code_q    <= '0;
            key_release_q <= 1'b0;
            key_ext_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            rel_flag_q    <= 1'b0;
            ext_flag_q    <= 1'b0;
        end else begin
            code_q        <= code_d;
            code_valid_q  <= code_valid_d;
            hist_q        <= hist_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_release_q <= key_release_d;
            key_ext_q     <= key_ext_d;
            frame_err_q   <= frame_err_d;
            rel_flag_q    <= rel_flag_d;
            ext_flag_q    <= ext_flag_d;
        end
    end

    assign bus.code        = code_q;
    assign bus.code_valid  = code_valid_q;
    assign bus.keycodeout  = hist_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_release = key_release_q;
    assign bus.key_ext     = key_ext_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx. It drives PS/2 frames on the pins and records
// every output pulse. It compares the pulses with spec constants and with
// a byte-level model of the history and the key decode.
`timescale 1ns/1ps
module tb_ps2_scan_rx;
    localparam int FILT = 8;
    localparam int TMO  = 400;
    localparam int HALF = 40;
    localparam int Q    = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    ps2_scan_rx_if bus();

    ps2_scan_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int last_err_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [39:0] obs_cv_q[$];
    logic [39:0] exp_cv_q[$];
    logic [9:0]  obs_key_q[$];
    logic [9:0]  exp_key_q[$];
    int          obs_err_n = 0;
    int          exp_err_n = 0;
    logic [31:0] m_hist = '0;
    bit          m_rel = 1'b0;
    bit          m_ext = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.code_valid) obs_cv_q.push_back({bus.code, bus.keycodeout});
            if (bus.key_valid) obs_key_q.push_back({bus.key_code, bus.key_release, bus.key_ext});
            if (bus.frame_err) begin
                obs_err_n++;
                last_err_cyc = cyc;
            end
        end
    end

    // Reference model: one call per accepted byte.
    task automatic model_byte(input logic [7:0] b);
        m_hist = {m_hist[23:0], b};
        exp_cv_q.push_back({b, m_hist});
        if (b == 8'hF0) m_rel = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            exp_key_q.push_back({b, m_rel, m_ext});
            m_rel = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_cv_q.delete();
        exp_cv_q.delete();
        obs_key_q.delete();
        exp_key_q.delete();
        obs_err_n = 0;
        exp_err_n = 0;
    endtask

    task automatic do_reset();
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        wait_cyc(5);
        rst = 1'b0;
        m_hist = '0;
        m_rel  = 1'b0;
        m_ext  = 1'b0;
        wait_cyc(20);
        clear_obs();
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        bus.ps2_data = v;
        wait_cyc(Q);
        bus.ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b1;
        if (glitch) begin
            wait_cyc(5);
            bus.ps2_clk = 1'b0;
            wait_cyc(3);
            bus.ps2_clk = 1'b1;
            wait_cyc(Q - 8);
        end else begin
            wait_cyc(Q);
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input int glitch_bit);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i], i == glitch_bit);
        bus.ps2_data = 1'b1;
        wait_cyc(60);
        if (!bad_par && !bad_stop) model_byte(b);
        else exp_err_n++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [52:0] outs;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        wait_cyc(4);
        outs = {bus.code, bus.code_valid, bus.keycodeout, bus.key_valid, bus.key_code,
                bus.key_release, bus.key_ext, bus.frame_err};
        checks++;
        if (outs !== 53'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
        checks++;
        if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
        do_reset();
        outs = {bus.code, bus.code_valid, bus.keycodeout, bus.key_valid, bus.key_code,
                bus.key_release, bus.key_ext, bus.frame_err};
        checks++;
        if (outs !== 53'd0) begin errors++; $display("FAIL post_reset_idle: got %h want 0", outs); end
    endtask

    task automatic test_clean_frame();
        do_reset();
        drive_frame(8'h1C, 0, 0, -1);
        checks++;
        if (obs_cv_q.size() !== 1) begin errors++; $display("FAIL clean_cv_count: got %0d want 1", obs_cv_q.size()); end
        else begin
            checks++;
            if (obs_cv_q[0] !== {8'h1C, 32'h0000001C}) begin errors++; $display("FAIL clean_code_hist: got %h want 1c0000001c", obs_cv_q[0]); end
        end
        checks++;
        if (obs_key_q.size() !== 1) begin errors++; $display("FAIL clean_key_count: got %0d want 1", obs_key_q.size()); end
        else begin
            checks++;
            if (obs_key_q[0] !== {8'h1C, 1'b0, 1'b0}) begin errors++; $display("FAIL clean_key: got %h want %h", obs_key_q[0], {8'h1C, 2'b00}); end
        end
        checks++;
        if (obs_err_n !== 0) begin errors++; $display("FAIL clean_no_err: got %0d want 0", obs_err_n); end
        checks++;
        if (bus.key_code !== 8'h1C) begin errors++; $display("FAIL clean_key_hold: got %h want 1c", bus.key_code); end
    endtask

    task automatic test_release();
        do_reset();
        drive_frame(8'hF0, 0, 0, -1);
        drive_frame(8'h1C, 0, 0, -1);
        drive_frame(8'h1C, 0, 0, -1);
        checks++;
        if (obs_cv_q.size() !== 3) begin errors++; $display("FAIL rel_cv_count: got %0d want 3", obs_cv_q.size()); end
        else begin
            checks++;
            if (obs_cv_q[1] !== {8'h1C, 32'h0000F01C}) begin errors++; $display("FAIL rel_hist: got %h want 1c0000f01c", obs_cv_q[1]); end
        end
        checks++;
        if (obs_key_q.size() !== 2) begin errors++; $display("FAIL rel_key_count: got %0d want 2", obs_key_q.size()); end
        else begin
            checks++;
            if (obs_key_q[0] !== {8'h1C, 1'b1, 1'b0}) begin errors++; $display("FAIL rel_break: got %h want %h", obs_key_q[0], {8'h1C, 2'b10}); end
            checks++;
            if (obs_key_q[1] !== {8'h1C, 1'b0, 1'b0}) begin errors++; $display("FAIL rel_make_after: got %h want %h", obs_key_q[1], {8'h1C, 2'b00}); end
        end
    endtask

    task automatic test_ext();
        do_reset();
        drive_frame(8'hE0, 0, 0, -1);
        drive_frame(8'hF0, 0, 0, -1);
        drive_frame(8'h74, 0, 0, -1);
        drive_frame(8'h74, 0, 0, -1);
        checks++;
        if (obs_cv_q.size() !== 4) begin errors++; $display("FAIL ext_cv_count: got %0d want 4", obs_cv_q.size()); end
        else begin
            checks++;
            if (obs_cv_q[2] !== {8'h74, 32'h00E0F074}) begin errors++; $display("FAIL ext_hist: got %h want 7400e0f074", obs_cv_q[2]); end
        end
        checks++;
        if (obs_key_q.size() !== 2) begin errors++; $display("FAIL ext_key_count: got %0d want 2", obs_key_q.size()); end
        else begin
            checks++;
            if (obs_key_q[0] !== {8'h74, 1'b1, 1'b1}) begin errors++; $display("FAIL ext_event: got %h want %h", obs_key_q[0], {8'h74, 2'b11}); end
            checks++;
            if (obs_key_q[1] !== {8'h74, 1'b0, 1'b0}) begin errors++; $display("FAIL ext_flags_cleared: got %h want %h", obs_key_q[1], {8'h74, 2'b00}); end
        end
    endtask

    task automatic test_parity_err();
        clear_obs();
        drive_frame(8'h1C, 1, 0, -1);
        checks++;
        if (obs_err_n !== 1) begin errors++; $display("FAIL par_err_pulse: got %0d want 1", obs_err_n); end
        checks++;
        if (obs_cv_q.size() !== 0) begin errors++; $display("FAIL par_no_code: got %0d want 0", obs_cv_q.size()); end
        checks++;
        if (bus.keycodeout !== 32'hE0F07474) begin errors++; $display("FAIL par_hist_kept: got %h want e0f07474", bus.keycodeout); end
        drive_frame(8'h1C, 0, 0, -1);
        checks++;
        if (obs_cv_q.size() !== 1) begin errors++; $display("FAIL par_next_count: got %0d want 1", obs_cv_q.size()); end
        else begin
            checks++;
            if (obs_cv_q[0] !== {8'h1C, 32'hF074741C}) begin errors++; $display("FAIL par_next_ok: got %h want 1cf074741c", obs_cv_q[0]); end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        int delta;
        int budget;
        b = 8'h29;
        clear_obs();
        send_bit(1'b0, 0);
        for (int i = 0; i < 5; i++) send_bit(b[i], 0);
        bus.ps2_data = 1'b1;
        budget = 2 * TMO;
        while (obs_err_n == 0 && budget > 0) begin
            wait_cyc(1);
            budget--;
        end
        checks++;
        if (obs_err_n !== 1) begin errors++; $display("FAIL tmo_err_pulse: got %0d want 1", obs_err_n); end
        else begin
            delta = last_err_cyc - last_fall_cyc;
            checks++;
            if (delta < TMO || delta > TMO + 30) begin errors++; $display("FAIL tmo_delay: got %0d want %0d..%0d", delta, TMO, TMO + 30); end
        end
        wait_cyc(2);
        checks++;
        if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL tmo_idle: got %0d want 0", bus.state_dbg); end
        checks++;
        if (obs_cv_q.size() !== 0) begin errors++; $display("FAIL tmo_no_code: got %0d want 0", obs_cv_q.size()); end
        drive_frame(8'h29, 0, 0, -1);
        checks++;
        if (obs_cv_q.size() !== 1) begin errors++; $display("FAIL tmo_next_count: got %0d want 1", obs_cv_q.size()); end
        else begin
            checks++;
            if (obs_cv_q[0] !== exp_cv_q[0]) begin errors++; $display("FAIL tmo_next_code: got %h want %h", obs_cv_q[0], exp_cv_q[0]); end
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        bus.ps2_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(10);
            bus.ps2_clk = 1'b0;
            wait_cyc(3);
            bus.ps2_clk = 1'b1;
        end
        wait_cyc(30);
        checks++;
        if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL glitch_idle_state: got %0d want 0", bus.state_dbg); end
        bus.ps2_data = 1'b1;
        wait_cyc(10);
        drive_frame(8'hA5, 0, 0, 4);
        drive_frame(8'h3C, 0, 0, 9);
        checks++;
        if (obs_cv_q.size() !== 2) begin errors++; $display("FAIL glitch_cv_count: got %0d want 2", obs_cv_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_cv_q[i] !== exp_cv_q[i]) begin errors++; $display("FAIL glitch_code[%0d]: got %h want %h", i, obs_cv_q[i], exp_cv_q[i]); end
            end
        end
        checks++;
        if (obs_err_n !== 0) begin errors++; $display("FAIL glitch_no_err: got %0d want 0", obs_err_n); end
    endtask

    task automatic test_reset_mid();
        logic [52:0] outs;
        clear_obs();
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        rst = 1'b1;
        #1;
        outs = {bus.code, bus.code_valid, bus.keycodeout, bus.key_valid, bus.key_code,
                bus.key_release, bus.key_ext, bus.frame_err};
        checks++;
        if (outs !== 53'd0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", outs); end
        checks++;
        if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d want 0", bus.state_dbg); end
        do_reset();
        drive_frame(8'h5A, 0, 0, -1);
        checks++;
        if (obs_cv_q.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", obs_cv_q.size()); end
        else begin
            checks++;
            if (obs_cv_q[0] !== {8'h5A, 32'h0000005A}) begin errors++; $display("FAIL rstmid_code: got %h want 5a0000005a", obs_cv_q[0]); end
        end
        checks++;
        if (obs_key_q.size() !== 1 || obs_key_q[0] !== {8'h5A, 2'b00}) begin errors++; $display("FAIL rstmid_key: got %0d events want one 5a make", obs_key_q.size()); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        bit bp, bs;
        clear_obs();
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hF0;
            else if (r < 4) b = 8'hE0;
            else b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            bp = (r == 0);
            bs = (r == 1);
            drive_frame(b, bp, bs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
        end
        checks++;
        if (obs_cv_q.size() !== exp_cv_q.size()) begin errors++; $display("FAIL rnd_cv_count: got %0d want %0d", obs_cv_q.size(), exp_cv_q.size()); end
        else begin
            for (int i = 0; i < exp_cv_q.size(); i++) begin
                checks++;
                if (obs_cv_q[i] !== exp_cv_q[i]) begin errors++; $display("FAIL rnd_code[%0d]: got %h want %h", i, obs_cv_q[i], exp_cv_q[i]); end
            end
        end
        checks++;
        if (obs_key_q.size() !== exp_key_q.size()) begin errors++; $display("FAIL rnd_key_count: got %0d want %0d", obs_key_q.size(), exp_key_q.size()); end
        else begin
            for (int i = 0; i < exp_key_q.size(); i++) begin
                checks++;
                if (obs_key_q[i] !== exp_key_q[i]) begin errors++; $display("FAIL rnd_key[%0d]: got %h want %h", i, obs_key_q[i], exp_key_q[i]); end
            end
        end
        checks++;
        if (obs_err_n !== exp_err_n) begin errors++; $display("FAIL rnd_err_count: got %0d want %0d", obs_err_n, exp_err_n); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_clean_frame();
        test_release();
        test_ext();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
